// File: rtl/mips16_pkg.sv
// rtl/mips16_pkg.sv - shared opcode, field and decode definitions for the 16-bit MIPS pipeline
package mips16_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RS_HI = 11;
  localparam int RS_LO = 10;
  localparam int RT_HI = 9;
  localparam int RT_LO = 8;
  localparam int RD_HI = 7;
  localparam int RD_LO = 6;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic [1:0]      rd_used;
    logic [1:0][1:0] src;
    logic            wr_en;
    logic [1:0]      dst;
    logic            is_lw;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] ir);
    logic [3:0] op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
    dec_t d;
    op = ir[OP_HI:OP_LO];
    rs = ir[RS_HI:RS_LO];
    rt = ir[RT_HI:RT_LO];
    rd = ir[RD_HI:RD_LO];
    d = '0;
    d.src[0] = rs;
    d.src[1] = rt;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        d.rd_used = 2'b11;
        d.wr_en   = 1'b1;
        d.dst     = rd;
      end
      OP_ADDI: begin
        d.rd_used = 2'b01;
        d.wr_en   = 1'b1;
        d.dst     = rt;
      end
      OP_LW: begin
        d.rd_used = 2'b01;
        d.wr_en   = 1'b1;
        d.dst     = rt;
        d.is_lw   = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: d.rd_used = 2'b11;
      default: ;
    endcase
    // $0 is hard-wired, so writes to it never need tracking
    if (d.dst == 2'd0) d.wr_en = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown of in-flight writes and ID read-hazard compare
module hazard_scoreboard
  import mips16_pkg::*;
#(
  parameter int WB_LAT   = 2,
  parameter int LW_EXTRA = 1
) (
  input  logic clock,
  input  logic resetn,
  input  dec_t dec,
  input  logic check_en,
  input  logic issue,
  output logic hazard
);

  // The issue cycle is the first of the latency cycles, so the countdown
  // starts one below the latency and reaches zero exactly when readable.
  localparam logic [1:0] LD_ALU = 2'(WB_LAT - 1);
  localparam logic [1:0] LD_LW  = 2'(WB_LAT + LW_EXTRA - 1);

  logic [1:0] cnt [4];

  always_ff @(negedge clock) begin
    if (!resetn) begin
      for (int r = 0; r < 4; r++) cnt[r] <= 2'd0;
    end else begin
      cnt[0] <= 2'd0;
      for (int r = 1; r < 4; r++) begin
        if (issue && dec.wr_en && dec.dst == 2'(r))
          cnt[r] <= dec.is_lw ? LD_LW : LD_ALU;
        else if (cnt[r] != 2'd0)
          cnt[r] <= cnt[r] - 2'd1;
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (dec.rd_used[i] && dec.src[i] != 2'd0 && cnt[dec.src[i]] != 2'd0)
        hazard = 1'b1;
    end
    hazard = hazard & check_en;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller: FSM, pipeline control outputs and perf counters
module pipe_hazard_ctrl
  import mips16_pkg::*;
#(
  parameter int WB_LAT   = 2,
  parameter int LW_EXTRA = 1,
  parameter int BR_FLUSH = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] ifid_ir,
  input  logic        ifid_valid,
  input  logic        ex_br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  dec_t       dec;
  logic       hazard;
  logic       flush_now;
  logic       issue;
  hz_state_t  state;
  hz_state_t  state_n;
  logic [1:0] fl_cnt;
  logic [1:0] fl_n;
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  assign dec       = decode(ifid_ir);
  // A taken branch squashes the ID instruction in the very cycle it resolves
  assign flush_now = ex_br_taken || (state == ST_FLUSH);
  assign issue     = resetn && ifid_valid && !hazard && !flush_now;

  hazard_scoreboard #(
    .WB_LAT   (WB_LAT),
    .LW_EXTRA (LW_EXTRA)
  ) u_scoreboard (
    .clock    (clock),
    .resetn   (resetn),
    .dec      (dec),
    .check_en (ifid_valid),
    .issue    (issue),
    .hazard   (hazard)
  );

  always_comb begin
    state_n     = state;
    fl_n        = fl_cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (flush_now) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (ex_br_taken) begin
        fl_n    = 2'(BR_FLUSH - 1);
        state_n = (BR_FLUSH > 1) ? ST_FLUSH : ST_RUN;
      end else begin
        fl_n    = fl_cnt - 2'd1;
        state_n = (fl_cnt <= 2'd1) ? ST_RUN : ST_FLUSH;
      end
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_n     = ST_STALL;
    end else begin
      state_n = ST_RUN;
    end
    if (!resetn) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end
  end

  always_ff @(negedge clock) begin
    if (!resetn) begin
      state   <= ST_RUN;
      fl_cnt  <= 2'd0;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state  <= state_n;
      fl_cnt <= fl_n;
      if (hazard && !flush_now && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (flush_now && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl against a ready-time model
module tb_pipe_hazard_ctrl;

  localparam int WB = 2;
  localparam int LE = 1;
  localparam int BF = 1;

  logic        clock = 1'b0;
  logic        resetn;
  logic [15:0] ifid_ir;
  logic        ifid_valid;
  logic        ex_br_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        ifid_flush;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: absolute cycle at which each register becomes readable in ID
  int t = 0;
  int ready [4];
  int flush_until = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_issued;

  pipe_hazard_ctrl #(.WB_LAT(WB), .LW_EXTRA(LE), .BR_FLUSH(BF)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .ifid_ir     (ifid_ir),
    .ifid_valid  (ifid_valid),
    .ex_br_taken (ex_br_taken),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_bubble (idex_bubble),
    .ifid_flush  (ifid_flush),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic void mdl_dec(input logic [15:0] ir, output logic [3:0] rmask,
                                  output int wreg, output int lat);
    int op, rs, rt, rd;
    op = int'(ir) / 4096;
    rs = (int'(ir) / 1024) % 4;
    rt = (int'(ir) / 256) % 4;
    rd = (int'(ir) / 64) % 4;
    rmask = 4'b0;
    wreg  = 0;
    lat   = WB;
    case (op)
      0, 1, 2, 3, 7: begin rmask[rs] = 1'b1; rmask[rt] = 1'b1; wreg = rd; end
      4:             begin rmask[rs] = 1'b1; wreg = rt; end
      5:             begin rmask[rs] = 1'b1; wreg = rt; lat = WB + LE; end
      6, 8, 9:       begin rmask[rs] = 1'b1; rmask[rt] = 1'b1; end
      default: ;
    endcase
    rmask[0] = 1'b0;
  endfunction

  // One pipeline cycle: drive after posedge, check before the negedge update, advance model
  task automatic step(input logic [15:0] ir, input logic v, input logic br, input logic rn);
    logic [3:0] rmask;
    int wreg, lat;
    bit hz, fl;
    logic [3:0] exp_ctl;
    ifid_ir = ir; ifid_valid = v; ex_br_taken = br; resetn = rn;
    #2;
    mdl_dec(ir, rmask, wreg, lat);
    hz = 1'b0;
    for (int r = 1; r < 4; r++) if (v && rmask[r] && ready[r] > t) hz = 1'b1;
    fl = br || (t < flush_until);
    m_issued = 1'b0;
    if (!rn)     exp_ctl = 4'b0011;
    else if (fl) exp_ctl = 4'b1111;
    else if (hz) exp_ctl = 4'b0010;
    else         exp_ctl = 4'b1100;
    check("ctl", {28'd0, pc_write, ifid_write, idex_bubble, ifid_flush}, {28'd0, exp_ctl});
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
    check("flush_cnt", {16'd0, flush_cnt}, m_flush);
    if (!rn) begin
      for (int r = 0; r < 4; r++) ready[r] = 0;
      flush_until = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (fl) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      else if (hz) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      else if (v) begin
        m_issued = 1'b1;
        if (wreg != 0) ready[wreg] = t + lat;
      end
      if (br) flush_until = t + BF;
    end
    t++;
    @(posedge clock);
    #1;
  endtask

  task automatic issue_instr(input logic [15:0] ir);
    for (int k = 0; k < 8; k++) begin
      step(ir, 1'b1, 1'b0, 1'b1);
      if (m_issued) break;
    end
  endtask

  task automatic do_reset();
    step(16'h0, 1'b0, 1'b0, 1'b0);
    step(16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] rtype(input int op, input int rs, input int rt, input int rd);
    return 16'((op * 4096) + (rs * 1024) + (rt * 256) + (rd * 64));
  endfunction

  initial begin
    int ops [11];
    ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12};
    resetn = 1'b0; ifid_ir = '0; ifid_valid = 1'b0; ex_br_taken = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    // addi $1,$0,15 then and $3,$1,$2: one stall
    issue_instr({4'h4, 2'd0, 2'd1, 8'd15});
    issue_instr(rtype(2, 1, 2, 3));
    step(16'h0, 1'b0, 1'b0, 1'b1);
    check("t1_stall", {16'd0, stall_cnt}, 32'd1);

    // lw $2 then add $3,$2,$1: two stalls, then $2 free
    do_reset();
    issue_instr(rtype(5, 0, 2, 0));
    issue_instr(rtype(0, 2, 1, 3));
    step(rtype(1, 2, 2, 0), 1'b1, 1'b0, 1'b1);
    check("t2_stall", {16'd0, stall_cnt}, 32'd2);

    // $0 writes and reads never hazard
    do_reset();
    issue_instr(rtype(0, 0, 0, 0));
    issue_instr(rtype(1, 0, 0, 3));
    step(16'h0, 1'b0, 1'b0, 1'b1);
    check("t3_stall", {16'd0, stall_cnt}, 32'd0);

    // branch taken during stall: flush wins, stalled and never issues
    do_reset();
    issue_instr(rtype(5, 0, 1, 0));
    step(rtype(2, 1, 2, 3), 1'b1, 1'b0, 1'b1);
    step(rtype(2, 1, 2, 3), 1'b1, 1'b1, 1'b1);
    for (int k = 1; k < BF; k++) step(rtype(2, 1, 2, 3), 1'b1, 1'b0, 1'b1);
    step(rtype(0, 3, 3, 2), 1'b1, 1'b0, 1'b1);
    check("t4_flush", {16'd0, flush_cnt}, BF);
    check("t4_stall", {16'd0, stall_cnt}, 32'd1);

    // reset mid-stall discards pending write to $1
    do_reset();
    issue_instr(rtype(5, 0, 1, 0));
    step(rtype(0, 1, 2, 3), 1'b1, 1'b0, 1'b1);
    step(rtype(0, 1, 2, 3), 1'b1, 1'b0, 1'b0);
    step(rtype(0, 1, 2, 3), 1'b1, 1'b0, 1'b0);
    step(rtype(0, 1, 2, 3), 1'b1, 1'b0, 1'b1);
    step(16'h0, 1'b0, 1'b0, 1'b1);
    check("t5_stall", {16'd0, stall_cnt}, 32'd0);
    check("t5_flush", {16'd0, flush_cnt}, 32'd0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ir;
      ir = rtype(ops[$urandom_range(10)], int'($urandom_range(3)), int'($urandom_range(3)),
                 int'($urandom_range(3)));
      step(ir, ($urandom_range(9) != 0), ($urandom_range(19) == 0), ($urandom_range(99) != 0));
    end

    // stall counter saturation
    do_reset();
    step(16'h0, 1'b0, 1'b0, 1'b1);
    force dut.stall_q = 16'hFFF0;
    #1;
    release dut.stall_q;
    m_stall = 16'hFFF0;
    for (int i = 0; i < 30; i++) issue_instr(rtype(5, 1, 1, 0));
    step(16'h0, 1'b0, 1'b0, 1'b1);
    check("t6_sat", {16'd0, stall_cnt}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
